// File: rtl/pe_out_pkg.sv
// Shared defaults and read-FSM state type for the PE result packer.
package pe_out_pkg;

  localparam int unsigned X_PE_DEF   = 16;
  localparam int unsigned IN_BIT_DEF = 24;
  localparam int unsigned Q_BIT_DEF  = 8;
  localparam int unsigned NPOS_DEF   = 4;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam int unsigned SHIFT_W    = 5;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/quant_lane.sv
// One requantization lane: round-half-up, arithmetic shift, optional ReLU, saturate.
module quant_lane
  import pe_out_pkg::*;
#(
  parameter int unsigned IN_BIT = IN_BIT_DEF,
  parameter int unsigned Q_BIT  = Q_BIT_DEF
) (
  input  logic [IN_BIT-1:0]  x,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu_en,
  output logic [Q_BIT-1:0]   q_c
);

  // One guard bit so the rounding add cannot wrap.
  localparam int unsigned W      = IN_BIT + 1;
  localparam int          QMAX_I = (1 << (Q_BIT - 1)) - 1;
  localparam logic signed [W-1:0] QMAX = W'(QMAX_I);
  localparam logic signed [W-1:0] QMIN = W'(-QMAX_I - 1);

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] res;

  always_comb begin
    ext = {x[IN_BIT-1], x};
    rnd = '0;
    if (shift != '0) begin
      rnd = W'(1) << (shift - SHIFT_W'(1));
    end
    sum = ext + rnd;
    res = sum >>> shift;
    if (relu_en && res[W-1]) begin
      res = '0;
    end
    q_c = res[Q_BIT-1:0];
    if (res > QMAX) begin
      q_c = QMAX[Q_BIT-1:0];
    end else if (res < QMIN) begin
      q_c = QMIN[Q_BIT-1:0];
    end
  end

endmodule

// File: rtl/pe_result_packer.sv
// Quantizes PE tiles, buffers them in a small register FIFO and streams them
// out one word per handshake (NPOS words for unpooled tiles, one for pooled).
module pe_result_packer
  import pe_out_pkg::*;
#(
  parameter int unsigned X_PE   = X_PE_DEF,
  parameter int unsigned IN_BIT = IN_BIT_DEF,
  parameter int unsigned Q_BIT  = Q_BIT_DEF,
  parameter int unsigned NPOS   = NPOS_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          poolop,
  input  logic [IN_BIT*NPOS*X_PE-1:0]   result_unpool,
  input  logic [IN_BIT*X_PE-1:0]        result_pool,
  input  logic [SHIFT_W-1:0]            shift,
  input  logic                          relu_en,
  output logic                          in_ready,
  output logic [Q_BIT*X_PE-1:0]         out_data,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          overflow
);

  localparam int unsigned WORD_W = Q_BIT * X_PE;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned WIDX_W = (NPOS > 1) ? $clog2(NPOS) : 1;

  logic [NPOS-1:0][WORD_W-1:0]             tile_c;
  logic [DEPTH-1:0][NPOS-1:0][WORD_W-1:0]  buf_q;
  logic [DEPTH-1:0]                        mode_q;

  rd_state_e          state_q, state_n;
  logic [WIDX_W-1:0]  w_q, w_n;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0]   count_q, count_n;
  logic               overflow_n;
  logic               out_valid_n;
  logic               out_last_n;
  logic [WORD_W-1:0]  out_data_n;

  logic               hs_c;
  logic               pop_c;
  logic               push_c;
  logic               bypass_c;
  logic               head_mode_c;
  logic [WORD_W-1:0]  head_word_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Position 0 lanes are shared with the pooled path through a mode mux.
  for (genvar p = 0; p < NPOS; p++) begin : g_pos
    for (genvar i = 0; i < X_PE; i++) begin : g_lane
      logic [IN_BIT-1:0] x;
      logic [Q_BIT-1:0]  q_c;
      if (p == 0) begin : g_p0
        assign x = poolop ? result_pool[i*IN_BIT +: IN_BIT]
                          : result_unpool[(i*NPOS)*IN_BIT +: IN_BIT];
      end else begin : g_pn
        assign x = result_unpool[(i*NPOS+p)*IN_BIT +: IN_BIT];
      end
      quant_lane #(
        .IN_BIT (IN_BIT),
        .Q_BIT  (Q_BIT)
      ) u_quant (
        .x       (x),
        .shift   (shift),
        .relu_en (relu_en),
        .q_c     (q_c)
      );
      assign tile_c[p][i*Q_BIT +: Q_BIT] = q_c;
    end
  end

  // Next-state, buffer bookkeeping and next output word.
  always_comb begin
    state_n     = state_q;
    w_n         = w_q;
    wr_ptr_n    = wr_ptr_q;
    rd_ptr_n    = rd_ptr_q;
    overflow_n  = overflow;

    hs_c     = out_valid && out_ready;
    pop_c    = hs_c && out_last;
    in_ready = (count_q < CNT_W'(DEPTH)) || pop_c;
    push_c   = in_valid && in_ready;

    if (push_c) wr_ptr_n = ptr_inc(wr_ptr_q);
    if (pop_c)  rd_ptr_n = ptr_inc(rd_ptr_q);
    count_n = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (in_valid && !in_ready) overflow_n = 1'b1;

    if (pop_c) begin
      w_n = '0;
    end else if (hs_c) begin
      w_n = w_q + WIDX_W'(1);
    end

    case (state_q)
      RD_IDLE: if (count_n != '0) state_n = RD_SEND;
      RD_SEND: if (count_n == '0) state_n = RD_IDLE;
      default: state_n = RD_IDLE;
    endcase

    // A tile written into an otherwise empty buffer is forwarded straight to the output.
    bypass_c    = push_c && (count_q == CNT_W'(pop_c));
    head_mode_c = bypass_c ? poolop : mode_q[rd_ptr_n];
    head_word_c = bypass_c ? tile_c[w_n] : buf_q[rd_ptr_n][w_n];

    out_valid_n = (state_n == RD_SEND);
    out_data_n  = out_valid_n ? head_word_c : '0;
    out_last_n  = out_valid_n && (head_mode_c || (w_n == WIDX_W'(NPOS - 1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RD_IDLE;
      w_q       <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_n;
      w_q       <= w_n;
      wr_ptr_q  <= wr_ptr_n;
      rd_ptr_q  <= rd_ptr_n;
      count_q   <= count_n;
      overflow  <= overflow_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_data  <= out_data_n;
    end
  end

  // Tile storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) begin
      buf_q[wr_ptr_q]  <= tile_c;
      mode_q[wr_ptr_q] <= poolop;
    end
  end

endmodule
